// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB, stalls on mem_ready_i,
// traps illegal opcodes and memory timeouts into a sticky ERROR state.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int ALUOP_W = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [5:0]         instr_op_i,
    input  logic               mem_ready_i,
    output logic               PCWrite_o,
    output logic               PCWriteCond_o,
    output logic               Branch_ne_o,
    output logic               IorD_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               IRWrite_o,
    output logic [1:0]         MemtoReg_o,
    output logic [1:0]         PCSource_o,
    output logic [ALUOP_W-1:0] ALU_op_o,
    output logic               ALUSrcA_o,
    output logic [1:0]         ALUSrcB_o,
    output logic               RegWrite_o,
    output logic               RegDst_o,
    output logic               err_o,
    output logic [1:0]         err_code_o,
    output logic [3:0]         state_o
);

    // state     | meaning
    // IDLE      | post-reset, one cycle
    // FETCH     | read instruction at PC, PC += 4 on ready
    // DECODE    | branch target precompute, opcode dispatch
    // MEM_ADDR  | effective address for lw/sw
    // MEM_RD    | data read, waits for ready
    // MEM_WB    | load result into rt
    // MEM_WR    | data write, waits for ready
    // EXEC_R    | R-type ALU operation
    // R_WB      | R-type result into rd
    // EXEC_I    | immediate ALU operation
    // I_WB      | immediate result into rt
    // BRANCH    | compare and conditional PC load
    // JUMP      | PC <= jump target
    // ERROR     | sticky trap, left only through rst_i
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_R_WB     = 4'd8,
        S_EXEC_I   = 4'd9,
        S_I_WB     = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_ERROR    = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALU_BEQ   = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(3'b010);
    localparam logic [ALUOP_W-1:0] ALU_BNE   = ALUOP_W'(3'b011);
    localparam logic [ALUOP_W-1:0] ALU_SLTI  = ALUOP_W'(3'b100);
    localparam logic [ALUOP_W-1:0] ALU_LUI   = ALUOP_W'(3'b101);
    localparam logic [ALUOP_W-1:0] ALU_ORI   = ALUOP_W'(3'b110);
    localparam logic [ALUOP_W-1:0] ALU_SLTIU = ALUOP_W'(3'b111);

    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // A zero TIMEOUT still gets a 1-bit counter so the declarations stay legal.
    localparam int              CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int              LIM_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0]   LIMIT = LIM_I[CW-1:0];
    localparam bit              TO_EN = (TIMEOUT > 0);

    state_t               r_state;
    state_t               w_next;
    logic [5:0]           r_op;
    logic [5:0]           w_op;
    logic [CW-1:0]        r_wait_cnt;
    logic                 w_mem_wait;
    logic                 w_timeout;
    logic [1:0]           w_err_code;
    logic                 w_fetch_done;

    logic                 r_err;
    logic [1:0]           r_err_code;
    logic                 r_pc_write;
    logic                 r_pc_write_cond;
    logic                 r_branch_ne;
    logic                 r_iord;
    logic                 r_mem_read;
    logic                 r_mem_write;
    logic [1:0]           r_mem_to_reg;
    logic [1:0]           r_pc_source;
    logic [ALUOP_W-1:0]   r_alu_op;
    logic                 r_alu_src_a;
    logic [1:0]           r_alu_src_b;
    logic                 r_reg_write;
    logic                 r_reg_dst;

    assign w_mem_wait   = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_timeout    = TO_EN && (r_wait_cnt == LIMIT) && !mem_ready_i;
    assign w_op         = (r_state == S_DECODE) ? instr_op_i : r_op;
    assign w_fetch_done = (r_state == S_FETCH) && mem_ready_i;

    always_comb begin
        w_next     = r_state;
        w_err_code = 2'b00;
        case (r_state)
            S_IDLE:  w_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready_i) begin
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next     = S_ERROR;
                    w_err_code = ERR_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (instr_op_i)
                    OP_LW, OP_SW:                   w_next = S_MEM_ADDR;
                    OP_RTYPE:                       w_next = S_EXEC_R;
                    OP_BEQ, OP_BNE:                 w_next = S_BRANCH;
                    OP_J:                           w_next = S_JUMP;
                    OP_ADDI, OP_SLTIU, OP_SLTI,
                    OP_ORI, OP_LUI:                 w_next = S_EXEC_I;
                    default: begin
                        w_next     = S_ERROR;
                        w_err_code = ERR_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADDR: w_next = (r_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready_i) begin
                    w_next = S_MEM_WB;
                end else if (w_timeout) begin
                    w_next     = S_ERROR;
                    w_err_code = ERR_TIMEOUT;
                end
            end
            S_MEM_WB: w_next = S_FETCH;
            S_MEM_WR: begin
                if (mem_ready_i) begin
                    w_next = S_FETCH;
                end else if (w_timeout) begin
                    w_next     = S_ERROR;
                    w_err_code = ERR_TIMEOUT;
                end
            end
            S_EXEC_R: w_next = S_R_WB;
            S_R_WB:   w_next = S_FETCH;
            S_EXEC_I: w_next = S_I_WB;
            S_I_WB:   w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            S_ERROR:  w_next = S_ERROR;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are valid from the first cycle of each state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state         <= S_IDLE;
            r_op            <= '0;
            r_wait_cnt      <= '0;
            r_err           <= 1'b0;
            r_err_code      <= 2'b00;
            r_pc_write      <= 1'b0;
            r_pc_write_cond <= 1'b0;
            r_branch_ne     <= 1'b0;
            r_iord          <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_to_reg    <= 2'b00;
            r_pc_source     <= 2'b00;
            r_alu_op        <= '0;
            r_alu_src_a     <= 1'b0;
            r_alu_src_b     <= 2'b00;
            r_reg_write     <= 1'b0;
            r_reg_dst       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_op    <= w_op;

            if (w_next != r_state) begin
                r_wait_cnt <= '0;
            end else if (w_mem_wait && (r_wait_cnt != '1)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            if ((w_next == S_ERROR) && (r_state != S_ERROR)) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_code;
            end

            r_pc_write      <= 1'b0;
            r_pc_write_cond <= 1'b0;
            r_branch_ne     <= 1'b0;
            r_iord          <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_to_reg    <= 2'b00;
            r_pc_source     <= 2'b00;
            r_alu_op        <= ALU_ADD;
            r_alu_src_a     <= 1'b0;
            r_alu_src_b     <= 2'b00;
            r_reg_write     <= 1'b0;
            r_reg_dst       <= 1'b0;

            case (w_next)
                S_FETCH: begin
                    r_mem_read  <= 1'b1;
                    r_alu_src_b <= 2'b01;
                end
                S_DECODE: r_alu_src_b <= 2'b11;
                S_MEM_ADDR: begin
                    r_alu_src_a <= 1'b1;
                    r_alu_src_b <= 2'b10;
                end
                S_MEM_RD: begin
                    r_mem_read <= 1'b1;
                    r_iord     <= 1'b1;
                end
                S_MEM_WB: begin
                    r_reg_write  <= 1'b1;
                    r_mem_to_reg <= 2'b01;
                end
                S_MEM_WR: begin
                    r_mem_write <= 1'b1;
                    r_iord      <= 1'b1;
                end
                S_EXEC_R: begin
                    r_alu_src_a <= 1'b1;
                    r_alu_op    <= ALU_FUNCT;
                end
                S_R_WB: begin
                    r_reg_write <= 1'b1;
                    r_reg_dst   <= 1'b1;
                end
                S_EXEC_I: begin
                    r_alu_src_a <= 1'b1;
                    r_alu_src_b <= 2'b10;
                    case (w_op)
                        OP_SLTIU: r_alu_op <= ALU_SLTIU;
                        OP_SLTI:  r_alu_op <= ALU_SLTI;
                        OP_ORI:   r_alu_op <= ALU_ORI;
                        OP_LUI:   r_alu_op <= ALU_LUI;
                        default:  r_alu_op <= ALU_ADD;
                    endcase
                end
                S_I_WB: r_reg_write <= 1'b1;
                S_BRANCH: begin
                    r_alu_src_a     <= 1'b1;
                    r_alu_op        <= (w_op == OP_BNE) ? ALU_BNE : ALU_BEQ;
                    r_pc_write_cond <= 1'b1;
                    r_pc_source     <= 2'b01;
                    r_branch_ne     <= (w_op == OP_BNE);
                end
                S_JUMP: begin
                    r_pc_write  <= 1'b1;
                    r_pc_source <= 2'b10;
                end
                default: ;
            endcase
        end
    end

    // FETCH's IR and PC loads follow mem_ready_i combinationally.
    assign PCWrite_o     = r_pc_write | w_fetch_done;
    assign IRWrite_o     = w_fetch_done;
    assign PCWriteCond_o = r_pc_write_cond;
    assign Branch_ne_o   = r_branch_ne;
    assign IorD_o        = r_iord;
    assign MemRead_o     = r_mem_read;
    assign MemWrite_o    = r_mem_write;
    assign MemtoReg_o    = r_mem_to_reg;
    assign PCSource_o    = r_pc_source;
    assign ALU_op_o      = r_alu_op;
    assign ALUSrcA_o     = r_alu_src_a;
    assign ALUSrcB_o     = r_alu_src_b;
    assign RegWrite_o    = r_reg_write;
    assign RegDst_o      = r_reg_dst;
    assign err_o         = r_err;
    assign err_code_o    = r_err_code;
    assign state_o       = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl (TIMEOUT = 4): per-cycle expected records go through
// a scoreboard queue; an opcode table drives the sweep, hand sequences cover stalls, traps and reset.
module tb_multicycle_ctrl;

    localparam logic [3:0] S_I   = 4'd0;
    localparam logic [3:0] S_F   = 4'd1;
    localparam logic [3:0] S_D   = 4'd2;
    localparam logic [3:0] S_MA  = 4'd3;
    localparam logic [3:0] S_MR  = 4'd4;
    localparam logic [3:0] S_MW  = 4'd5;
    localparam logic [3:0] S_WR  = 4'd6;
    localparam logic [3:0] S_ER  = 4'd7;
    localparam logic [3:0] S_RW  = 4'd8;
    localparam logic [3:0] S_EI  = 4'd9;
    localparam logic [3:0] S_IW  = 4'd10;
    localparam logic [3:0] S_BR  = 4'd11;
    localparam logic [3:0] S_J   = 4'd12;
    localparam logic [3:0] S_ERR = 4'd13;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic       bne;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic [1:0] m2r;
        logic [1:0] pcs;
        logic [2:0] alu;
        logic       srca;
        logic [1:0] srcb;
        logic       rw;
        logic       rdst;
    } ctrl_t;

    typedef struct {
        logic [3:0] st;
        ctrl_t      c;
        logic       err;
        logic [1:0] code;
        string      tag;
    } exp_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [3:0]  n;
        logic [19:0] path;
        logic [2:0]  alu;
    } vec_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [5:0] instr_op_i = 6'h00;
    logic       mem_ready_i = 1'b0;
    logic       PCWrite_o, PCWriteCond_o, Branch_ne_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o;
    logic [1:0] MemtoReg_o, PCSource_o, ALUSrcB_o, err_code_o;
    logic [2:0] ALU_op_o;
    logic       ALUSrcA_o, RegWrite_o, RegDst_o, err_o;
    logic [3:0] state_o;

    ctrl_t act;
    exp_t  sb[$];
    exp_t  e_cur;
    vec_t  tbl[11];
    int    n_cmp = 0;
    int    n_bad = 0;

    multicycle_ctrl #(.TIMEOUT(4), .ALUOP_W(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
        .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .Branch_ne_o(Branch_ne_o),
        .IorD_o(IorD_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o),
        .MemtoReg_o(MemtoReg_o), .PCSource_o(PCSource_o), .ALU_op_o(ALU_op_o),
        .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .RegWrite_o(RegWrite_o),
        .RegDst_o(RegDst_o), .err_o(err_o), .err_code_o(err_code_o), .state_o(state_o)
    );

    assign act = {PCWrite_o, PCWriteCond_o, Branch_ne_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
                  MemtoReg_o, PCSource_o, ALU_op_o, ALUSrcA_o, ALUSrcB_o, RegWrite_o, RegDst_o};

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    // Control outputs each state must show, straight from the state description table.
    function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic [5:0] op,
                                       input logic rdy, input logic [2:0] alu);
        ctrl_t c;
        c = '0;
        case (st)
            S_F:  begin c.mrd = 1'b1; c.srcb = 2'b01; c.irw = rdy; c.pcw = rdy; end
            S_D:  c.srcb = 2'b11;
            S_MA: begin c.srca = 1'b1; c.srcb = 2'b10; end
            S_MR: begin c.mrd = 1'b1; c.iord = 1'b1; end
            S_MW: begin c.rw = 1'b1; c.m2r = 2'b01; end
            S_WR: begin c.mwr = 1'b1; c.iord = 1'b1; end
            S_ER: begin c.srca = 1'b1; c.alu = 3'b010; end
            S_RW: begin c.rw = 1'b1; c.rdst = 1'b1; end
            S_EI: begin c.srca = 1'b1; c.srcb = 2'b10; c.alu = alu; end
            S_IW: c.rw = 1'b1;
            S_BR: begin
                c.srca = 1'b1; c.alu = alu; c.pcwc = 1'b1; c.pcs = 2'b01;
                c.bne = (op == 6'h05);
            end
            S_J:  begin c.pcw = 1'b1; c.pcs = 2'b10; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Drive one cycle; the opcode is only presented during DECODE, so later states must rely on the latched copy.
    task automatic step(input string tag, input logic [5:0] iop, input logic rdy, input logic [3:0] st,
                        input logic [2:0] alu, input logic err, input logic [1:0] code);
        exp_t e;
        instr_op_i  = (st == S_D) ? iop : ~iop;
        mem_ready_i = rdy;
        e.st   = st;
        e.c    = exp_ctrl(st, iop, rdy, alu);
        e.err  = err;
        e.code = code;
        e.tag  = tag;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        #1;
        chk("rst_state", 32'(state_o), 32'(S_I));
        chk("rst_err", 32'({err_o, err_code_o}), 32'd0);
        chk("rst_ctrl", 32'(act), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        for (int i = 0; i < int'(v.n); i++)
            step($sformatf("op%02h_c%0d", v.op, i), v.op, 1'b1, v.path[4*i +: 4], v.alu, 1'b0, 2'b00);
    endtask

    initial begin
        tbl[0]  = '{op: 6'h00, n: 4'd4, path: {4'd0, S_RW, S_ER, S_D, S_F}, alu: 3'b000};
        tbl[1]  = '{op: 6'h02, n: 4'd3, path: {4'd0, 4'd0, S_J, S_D, S_F}, alu: 3'b000};
        tbl[2]  = '{op: 6'h04, n: 4'd3, path: {4'd0, 4'd0, S_BR, S_D, S_F}, alu: 3'b001};
        tbl[3]  = '{op: 6'h05, n: 4'd3, path: {4'd0, 4'd0, S_BR, S_D, S_F}, alu: 3'b011};
        tbl[4]  = '{op: 6'h08, n: 4'd4, path: {4'd0, S_IW, S_EI, S_D, S_F}, alu: 3'b000};
        tbl[5]  = '{op: 6'h09, n: 4'd4, path: {4'd0, S_IW, S_EI, S_D, S_F}, alu: 3'b111};
        tbl[6]  = '{op: 6'h0A, n: 4'd4, path: {4'd0, S_IW, S_EI, S_D, S_F}, alu: 3'b100};
        tbl[7]  = '{op: 6'h0D, n: 4'd4, path: {4'd0, S_IW, S_EI, S_D, S_F}, alu: 3'b110};
        tbl[8]  = '{op: 6'h0F, n: 4'd4, path: {4'd0, S_IW, S_EI, S_D, S_F}, alu: 3'b101};
        tbl[9]  = '{op: 6'h23, n: 4'd5, path: {S_MW, S_MR, S_MA, S_D, S_F}, alu: 3'b000};
        tbl[10] = '{op: 6'h2B, n: 4'd4, path: {4'd0, S_WR, S_MA, S_D, S_F}, alu: 3'b000};

        fork
            forever begin
                @(negedge clk_i);
                if (sb.size() != 0) begin
                    e_cur = sb.pop_front();
                    n_cmp++;
                    if (state_o !== e_cur.st || act !== e_cur.c || err_o !== e_cur.err ||
                        err_code_o !== e_cur.code) begin
                        n_bad++;
                        $display("FAIL %s: got st=%0d ctrl=%h err=%b code=%b, want st=%0d ctrl=%h err=%b code=%b",
                                 e_cur.tag, state_o, act, err_o, err_code_o,
                                 e_cur.st, e_cur.c, e_cur.err, e_cur.code);
                    end
                end
            end
        join_none

        @(posedge clk_i);
        #1;
        apply_reset();
        step("idle", 6'h00, 1'b1, S_I, 3'b000, 1'b0, 2'b00);

        // R-type first, then every legal opcode back to back
        run_vec(tbl[0]);
        for (int k = 0; k < 11; k++) run_vec(tbl[k]);

        // lw with three stalled MEM_RD cycles; ready arrives on the limit cycle and wins
        step("lw_f", 6'h23, 1'b1, S_F, 3'b000, 1'b0, 2'b00);
        step("lw_d", 6'h23, 1'b1, S_D, 3'b000, 1'b0, 2'b00);
        step("lw_ma", 6'h23, 1'b0, S_MA, 3'b000, 1'b0, 2'b00);
        for (int k = 0; k < 3; k++) step("lw_stall", 6'h23, 1'b0, S_MR, 3'b000, 1'b0, 2'b00);
        step("lw_rdy", 6'h23, 1'b1, S_MR, 3'b000, 1'b0, 2'b00);
        step("lw_wb", 6'h23, 1'b1, S_MW, 3'b000, 1'b0, 2'b00);

        // illegal opcode traps and sticks regardless of ready
        step("ill_f", 6'h3F, 1'b1, S_F, 3'b000, 1'b0, 2'b00);
        step("ill_d", 6'h3F, 1'b1, S_D, 3'b000, 1'b0, 2'b00);
        for (int k = 0; k < 4; k++)
            step("ill_err", 6'h3F, 1'(k & 1), S_ERR, 3'b000, 1'b1, 2'b01);
        apply_reset();
        step("ill_idle", 6'h00, 1'b0, S_I, 3'b000, 1'b0, 2'b00);

        // FETCH timeout: exactly four FETCH cycles without ready
        for (int k = 0; k < 4; k++) step("to_f", 6'h00, 1'b0, S_F, 3'b000, 1'b0, 2'b00);
        step("to_err", 6'h00, 1'b1, S_ERR, 3'b000, 1'b1, 2'b10);
        step("to_err2", 6'h00, 1'b0, S_ERR, 3'b000, 1'b1, 2'b10);
        apply_reset();
        step("to_idle", 6'h02, 1'b0, S_I, 3'b000, 1'b0, 2'b00);
        for (int k = 0; k < 3; k++) step("late_f", 6'h02, 1'b0, S_F, 3'b000, 1'b0, 2'b00);
        step("late_rdy", 6'h02, 1'b1, S_F, 3'b000, 1'b0, 2'b00);
        step("late_d", 6'h02, 1'b0, S_D, 3'b000, 1'b0, 2'b00);
        step("late_j", 6'h02, 1'b0, S_J, 3'b000, 1'b0, 2'b00);

        // reset mid MEM_WR: the write request drops without waiting for a clock
        step("sw_f", 6'h2B, 1'b1, S_F, 3'b000, 1'b0, 2'b00);
        step("sw_d", 6'h2B, 1'b1, S_D, 3'b000, 1'b0, 2'b00);
        step("sw_ma", 6'h2B, 1'b0, S_MA, 3'b000, 1'b0, 2'b00);
        step("sw_w0", 6'h2B, 1'b0, S_WR, 3'b000, 1'b0, 2'b00);
        step("sw_w1", 6'h2B, 1'b0, S_WR, 3'b000, 1'b0, 2'b00);
        chk("sw_memwrite_before_rst", 32'(MemWrite_o), 32'd1);
        rst_i = 1'b1;
        #1;
        chk("sw_memwrite_async_drop", 32'(MemWrite_o), 32'd0);
        chk("sw_state_async_idle", 32'(state_o), 32'(S_I));
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        step("post_idle", 6'h2B, 1'b0, S_I, 3'b000, 1'b0, 2'b00);

        // MEM_WR timeout
        step("swto_f", 6'h2B, 1'b1, S_F, 3'b000, 1'b0, 2'b00);
        step("swto_d", 6'h2B, 1'b1, S_D, 3'b000, 1'b0, 2'b00);
        step("swto_ma", 6'h2B, 1'b0, S_MA, 3'b000, 1'b0, 2'b00);
        for (int k = 0; k < 4; k++) step("swto_w", 6'h2B, 1'b0, S_WR, 3'b000, 1'b0, 2'b00);
        step("swto_err", 6'h2B, 1'b0, S_ERR, 3'b000, 1'b1, 2'b10);
        apply_reset();
        step("end_idle", 6'h00, 1'b1, S_I, 3'b000, 1'b0, 2'b00);
        step("end_f", 6'h00, 1'b1, S_F, 3'b000, 1'b0, 2'b00);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
